// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, ALUOp encodings and
// the packed decode control bundle carried from ID into EX.
package riscv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      ALU_OP_R  = 2'b00,
      ALU_OP_I  = 2'b01,
      ALU_OP_LS = 2'b10,
      ALU_OP_BR = 2'b11
   } alu_op_e;

   // MSB first: alu_op occupies [16:15], mem_to_reg is bit 0.
   typedef struct packed {
      alu_op_e    alu_op;
      logic [2:0] funct3;
      logic [6:0] funct7;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic       mem_to_reg;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic two-entry valid/ready buffer. The main entry drives the outputs;
// the skid entry absorbs the one extra word that arrives while the consumer
// stalls, so in_ready comes straight from a flop and never from out_ready.
module pipe_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             main_valid;
   logic             skid_valid;
   logic [WIDTH-1:0] main_data;
   logic [WIDTH-1:0] skid_data;

   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign out_data  = main_data;

   // Occupancy: flush wins; a full buffer only drains skid into main, otherwise
   // main refills when free/consumed and skid catches an input under stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (skid_valid) begin
         if (out_ready) begin
            skid_valid <= 1'b0;
         end
      end else if (!main_valid || out_ready) begin
         main_valid <= in_valid;
      end else if (in_valid) begin
         skid_valid <= 1'b1;
      end
   end

   // Payload: mirrors the occupancy decisions; words only move on a load so
   // a stalled main entry stays bit-for-bit stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_data <= '0;
         skid_data <= '0;
      end else if (!flush) begin
         if (skid_valid) begin
            if (out_ready) begin
               main_data <= skid_data;
            end
         end else if (!main_valid || out_ready) begin
            if (in_valid) begin
               main_data <= in_data;
            end
         end else if (in_valid) begin
            skid_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with skid buffering. The whole decode payload is
// buffered as one word; when the entry is empty the control bundle is
// neutralised so a bubble cannot write registers or memory.
module id_ex_stage #(
   parameter int XLEN   = riscv_pkg::XLEN,
   parameter int CTRL_W = riscv_pkg::CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [4:0]        in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [XLEN-1:0]   out_rs1_data,
   output logic [XLEN-1:0]   out_rs2_data,
   output logic [XLEN-1:0]   out_imm,
   output logic [XLEN-1:0]   out_pc,
   output logic [4:0]        out_rs1,
   output logic [4:0]        out_rs2,
   output logic [4:0]        out_rd
);

   import riscv_pkg::ctrl_t;
   import riscv_pkg::ALU_OP_LS;

   localparam int WIDTH = CTRL_W + 4 * XLEN + 15;

   logic [WIDTH-1:0]  in_payload;
   logic [WIDTH-1:0]  out_payload;
   logic [CTRL_W-1:0] held_ctrl;

   // Bubble control: plain add with every side-effecting enable cleared.
   function automatic ctrl_t mask_bubble(input ctrl_t c);
      ctrl_t m;
      m           = c;
      m.alu_op    = ALU_OP_LS;
      m.reg_write = 1'b0;
      m.mem_read  = 1'b0;
      m.mem_write = 1'b0;
      return m;
   endfunction

   assign in_payload = {in_ctrl, in_rs1_data, in_rs2_data, in_imm, in_pc,
                        in_rs1, in_rs2, in_rd};

   pipe_skid_buffer #(
      .WIDTH(WIDTH)
   ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_payload),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_payload)
   );

   assign {held_ctrl, out_rs1_data, out_rs2_data, out_imm, out_pc,
           out_rs1, out_rs2, out_rd} = out_payload;

   // Pass held control through for a live entry, neutralise it for a bubble.
   always_comb begin
      out_ctrl = held_ctrl;
      if (!out_valid) begin
         out_ctrl = mask_bubble(ctrl_t'(held_ctrl));
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver records every instruction the
// stage should accept, the negedge monitor checks handshakes and payloads.
module tb_id_ex_stage;

   localparam int XLEN = 32;
   localparam int CW   = 17;

   typedef struct packed {
      logic [CW-1:0]   ctrl;
      logic [XLEN-1:0] rs1d;
      logic [XLEN-1:0] rs2d;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
   } item_t;

   logic            clk;
   logic            rst;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [CW-1:0]   in_ctrl;
   logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
   logic [4:0]      in_rs1, in_rs2, in_rd;
   logic            out_valid;
   logic            out_ready;
   logic [CW-1:0]   out_ctrl;
   logic [XLEN-1:0] out_rs1_data, out_rs2_data, out_imm, out_pc;
   logic [4:0]      out_rs1, out_rs2, out_rd;

   item_t dut_item;
   item_t sb_q[$];
   bit    popped;
   bit    mon_en;
   int    n_checks;
   int    n_fail;

   id_ex_stage #(.XLEN(XLEN), .CTRL_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_ctrl     (in_ctrl),
      .in_rs1_data (in_rs1_data),
      .in_rs2_data (in_rs2_data),
      .in_imm      (in_imm),
      .in_pc       (in_pc),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .in_rd       (in_rd),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ctrl    (out_ctrl),
      .out_rs1_data(out_rs1_data),
      .out_rs2_data(out_rs2_data),
      .out_imm     (out_imm),
      .out_pc      (out_pc),
      .out_rs1     (out_rs1),
      .out_rs2     (out_rs2),
      .out_rd      (out_rd)
   );

   assign dut_item = {out_ctrl, out_rs1_data, out_rs2_data, out_imm, out_pc,
                      out_rs1, out_rs2, out_rd};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic item_t rand_item();
      item_t it;
      it.ctrl = CW'($urandom);
      it.rs1d = $urandom;
      it.rs2d = $urandom;
      it.imm  = $urandom;
      it.pc   = $urandom;
      it.rs1  = 5'($urandom);
      it.rs2  = 5'($urandom);
      it.rd   = 5'($urandom);
      return it;
   endfunction

   // One clock of stimulus; the reference model is a FIFO of depth two:
   // accept when fewer than two instructions are held, flush empties it.
   task automatic step(input logic iv, input logic fl, input logic ordy, input item_t it);
      int occ;
      in_valid  = iv;
      flush     = fl;
      out_ready = ordy;
      {in_ctrl, in_rs1_data, in_rs2_data, in_imm, in_pc, in_rs1, in_rs2, in_rd} = it;
      @(posedge clk);
      if (!rst) begin
         occ = sb_q.size() + (popped ? 1 : 0);
         if (fl) sb_q.delete();
         else if (iv && occ < 2) sb_q.push_back(it);
      end
      popped = 1'b0;
      #1;
   endtask

   // Monitor: handshake flags follow the model occupancy; a held entry must
   // match the oldest expected instruction, an empty stage must show a bubble.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         check("in_ready", 160'(in_ready), 160'(sb_q.size() < 2));
         check("out_valid", 160'(out_valid), 160'(sb_q.size() > 0));
         if (sb_q.size() > 0) begin
            check("out_payload", dut_item, sb_q[0]);
            if (out_ready) begin
               void'(sb_q.pop_front());
               popped = 1'b1;
            end
         end else begin
            check("bubble_ctrl", 160'({out_ctrl[16:15], out_ctrl[4], out_ctrl[3], out_ctrl[2]}),
                  160'(5'b10000));
         end
      end
   end

   task automatic check_reset_state();
      check("rst_out_valid", 160'(out_valid), 160'(1'b0));
      check("rst_in_ready", 160'(in_ready), 160'(1'b1));
      check("rst_regwrite", 160'(out_ctrl[4]), 160'(1'b0));
      check("rst_memwrite", 160'(out_ctrl[2]), 160'(1'b0));
      check("rst_outputs", dut_item, {17'h10000, 143'd0});
   endtask

   initial begin
      item_t it;
      n_checks = 0;
      n_fail   = 0;
      popped   = 1'b0;
      mon_en   = 1'b0;
      rst      = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      {in_ctrl, in_rs1_data, in_rs2_data, in_imm, in_pc, in_rs1, in_rs2, in_rd} = '0;
      #2;
      check_reset_state();
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      // back-to-back streaming
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, rand_item());
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, rand_item());

      // backpressure: third offer must wait for in_ready
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, rand_item());
      it = rand_item();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, it);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, rand_item());

      // bubble with side-effecting control on the idle input
      for (int i = 0; i < 3; i++) begin
         it = rand_item();
         it.ctrl = it.ctrl | 17'h00014;
         step(1'b0, 1'b0, 1'b1, it);
      end

      // flush with both entries full and a new offer
      step(1'b1, 1'b0, 1'b0, rand_item());
      step(1'b1, 1'b0, 1'b0, rand_item());
      step(1'b1, 1'b1, 1'b0, rand_item());
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, rand_item());

      // R-type held under stall
      it = rand_item();
      it.ctrl = {2'b00, 3'b000, 7'b0100000, 5'b10000};
      it.rd   = 5'd5;
      step(1'b1, 1'b0, 1'b0, it);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, rand_item());
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, rand_item());

      // asynchronous reset with entries held
      step(1'b1, 1'b0, 1'b0, rand_item());
      step(1'b1, 1'b0, 1'b0, rand_item());
      #2;
      rst = 1'b1;
      sb_q.delete();
      popped = 1'b0;
      #1;
      check_reset_state();
      step(1'b1, 1'b0, 1'b1, rand_item());
      rst = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, rand_item());

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 2) != 0), rand_item());
      end
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, rand_item());

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
